// File: rtl/sp_rx_sequencer_pkg.sv
// Frame-format constants and state encoding shared by the slave receive sequencer
// and the bus master's transmit sequencer.
package sp_rx_sequencer_pkg;

  localparam int STATE_BW   = 3;
  localparam int GAP_CYCLES = 2;
  localparam int ADDR_LEN   = 4;
  localparam int DATA_LEN   = 15;

  typedef enum logic [STATE_BW-1:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP  = 3'd2,
    DATA = 3'd3,
    SKIP = 3'd4,
    HOLD = 3'd5
  } state_t;

endpackage

// File: rtl/sp_rx_sequencer.sv
// Slave receive sequencer: steps an external serial_parallel converter through the
// address and data fields of a bus frame and presents matched payloads on valid/ready.
//
// state | meaning
// IDLE  | waiting for frame_start
// ADDR  | converter collecting the address field
// GAP   | converter cleared on the second gap bit, re-armed for data
// DATA  | converter collecting the data field
// SKIP  | address mismatch, waiting out the remainder of the frame
// HOLD  | payload presented, waiting for rx_ready
module sp_rx_sequencer #(
  parameter int PORT_WIDTH    = 15,
  parameter int EXTRACT_LNGTH = 4,
  parameter int ADDR_LEN      = sp_rx_sequencer_pkg::ADDR_LEN,
  parameter int DATA_LEN      = sp_rx_sequencer_pkg::DATA_LEN
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_start,
  input  logic                     frame_abort,
  input  logic [ADDR_LEN-1:0]      my_addr,
  output logic                     sp_en,
  output logic [EXTRACT_LNGTH-1:0] sp_bit_length,
  input  logic [PORT_WIDTH-1:0]    sp_dout,
  input  logic                     sp_dv,
  output logic [PORT_WIDTH-1:0]    rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     addr_hit,
  output logic                     overrun,
  output logic                     busy
);
  import sp_rx_sequencer_pkg::*;

  // SKIP spans the gap plus the data field; the counter ends on zero.
  localparam int SKIP_BW   = $clog2(DATA_LEN + 3);
  localparam int SKIP_LOAD = GAP_CYCLES + DATA_LEN - 1;

  state_t                   state, state_nxt;
  logic                     sp_en_nxt;
  logic [EXTRACT_LNGTH-1:0] sp_bit_length_nxt;
  logic [PORT_WIDTH-1:0]    rx_data_nxt;
  logic                     rx_valid_nxt;
  logic                     addr_hit_nxt;
  logic                     overrun_nxt;
  logic [SKIP_BW-1:0]       skip_cnt, skip_cnt_nxt;
  logic                     addr_match;

  assign addr_match = (sp_dout[ADDR_LEN-1:0] == my_addr);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt         = state;
    sp_en_nxt         = sp_en;
    sp_bit_length_nxt = sp_bit_length;
    rx_data_nxt       = rx_data;
    rx_valid_nxt      = rx_valid;
    addr_hit_nxt      = 1'b0;
    overrun_nxt       = 1'b0;
    skip_cnt_nxt      = skip_cnt;

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt         = ADDR;
          sp_en_nxt         = 1'b1;
          sp_bit_length_nxt = EXTRACT_LNGTH'(ADDR_LEN);
        end
      end
      ADDR: begin
        if (frame_abort) begin
          state_nxt = IDLE;
          sp_en_nxt = 1'b0;
        end else if (sp_dv) begin
          sp_en_nxt = 1'b0;
          if (addr_match) begin
            state_nxt         = GAP;
            addr_hit_nxt      = 1'b1;
            sp_bit_length_nxt = EXTRACT_LNGTH'(DATA_LEN);
          end else begin
            state_nxt    = SKIP;
            skip_cnt_nxt = SKIP_BW'(SKIP_LOAD);
          end
        end
      end
      GAP: begin
        if (frame_abort) begin
          state_nxt = IDLE;
          sp_en_nxt = 1'b0;
        end else begin
          state_nxt = DATA;
          sp_en_nxt = 1'b1;
        end
      end
      DATA: begin
        // Abort takes priority even on the cycle the field completes.
        if (frame_abort) begin
          state_nxt = IDLE;
          sp_en_nxt = 1'b0;
        end else if (sp_dv) begin
          state_nxt    = HOLD;
          sp_en_nxt    = 1'b0;
          rx_data_nxt  = sp_dout;
          rx_valid_nxt = 1'b1;
        end
      end
      SKIP: begin
        if (frame_abort || (skip_cnt == '0)) begin
          state_nxt = IDLE;
          sp_en_nxt = 1'b0;
        end else begin
          skip_cnt_nxt = skip_cnt - SKIP_BW'(1);
        end
      end
      HOLD: begin
        overrun_nxt = frame_start;
        if (rx_valid && rx_ready) begin
          state_nxt    = IDLE;
          rx_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        sp_en_nxt    = 1'b0;
        rx_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      sp_en         <= 1'b0;
      sp_bit_length <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      addr_hit      <= 1'b0;
      overrun       <= 1'b0;
      skip_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      sp_en         <= sp_en_nxt;
      sp_bit_length <= sp_bit_length_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      addr_hit      <= addr_hit_nxt;
      overrun       <= overrun_nxt;
      skip_cnt      <= skip_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sp_rx_sequencer.sv
// Bench for sp_rx_sequencer: a converter stand-in drives sp_dout/sp_dv from a serial
// bus bit, and a frame-timeline model predicts every output cycle by cycle.
module tb_sp_rx_sequencer;
  localparam int PW = 15;
  localparam int EL = 4;
  localparam int A  = 4;
  localparam int D  = 15;
  localparam int FRAME_END = A + D + 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_start = 1'b0;
  logic frame_abort = 1'b0;
  logic rx_ready = 1'b0;
  logic bus_bit = 1'b0;
  logic [A-1:0] my_addr = '0;
  logic sp_en, sp_dv, rx_valid, addr_hit, overrun, busy;
  logic [EL-1:0] sp_bit_length;
  logic [PW-1:0] sp_dout, rx_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_rx_sequencer #(.PORT_WIDTH(PW), .EXTRACT_LNGTH(EL), .ADDR_LEN(A), .DATA_LEN(D)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .frame_abort(frame_abort),
    .my_addr(my_addr), .sp_en(sp_en), .sp_bit_length(sp_bit_length), .sp_dout(sp_dout),
    .sp_dv(sp_dv), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .addr_hit(addr_hit), .overrun(overrun), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Converter stand-in: packs one bus bit per enabled clock, LSB first; en low clears it.
  int cv_cnt = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn || !sp_en) begin
      cv_cnt  <= 0;
      sp_dv   <= 1'b0;
      sp_dout <= '0;
    end else if (!sp_dv) begin
      sp_dout[cv_cnt] <= bus_bit;
      cv_cnt          <= cv_cnt + 1;
      if (cv_cnt + 1 == int'(sp_bit_length)) sp_dv <= 1'b1;
    end
  end

  // Timeline model: m_t is the cycle number within the frame (frame_start cycle = 0).
  bit m_active = 0, m_hold = 0, m_hit = 0, m_ovr = 0;
  int m_t = 0;
  logic [PW-1:0] m_data = '0;
  logic [EL-1:0] m_len = '0;
  logic [A-1:0]  fr_addr = '0;
  logic [PW-1:0] fr_data = '0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_active = 0; m_hold = 0; m_ovr = 0; m_t = 0; m_data = '0; m_len = '0;
    end else begin
      m_ovr = 0;
      if (m_hold) begin
        if (frame_start) m_ovr = 1;
        if (rx_ready) m_hold = 0;
      end else if (m_active) begin
        m_t++;
        if (frame_abort) m_active = 0;
        else if (m_t == FRAME_END) begin
          m_active = 0;
          if (m_hit) begin m_hold = 1; m_data = fr_data; end
        end else if (m_t == A + 2 && m_hit) m_len = EL'(D);
      end else if (frame_start) begin
        m_active = 1; m_t = 1; m_hit = (fr_addr == my_addr); m_len = EL'(A);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("sp_en", sp_en, m_active && (m_t <= A + 1 || (m_hit && m_t >= A + 3)));
      chk("sp_bit_length", sp_bit_length, m_len);
      chk("rx_valid", rx_valid, m_hold);
      chk("rx_data", rx_data, m_data);
      chk("addr_hit", addr_hit, m_active && m_hit && m_t == A + 2);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_active || m_hold);
    end
  end

  // Event log used by the hand-computed checks.
  int since_start = 0, hit_cyc = -1, val_cyc = -1, fall_cyc = -1, ovr_cnt = 0;
  bit prev_busy = 0;
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    since_start = frame_start ? 1 : since_start + 1;
  end

  initial forever begin
    @(negedge clk);
    if (addr_hit) hit_cyc = since_start;
    if (rx_valid && val_cyc < 0) val_cyc = since_start;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (overrun) ovr_cnt++;
    if (prev_busy && !busy) fall_cyc = since_start;
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    hit_cyc = -1; val_cyc = -1; fall_cyc = -1; ovr_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sp_en"}, sp_en, 0);
    chk({tag, "_sp_bit_length"}, sp_bit_length, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_addr_hit"}, addr_hit, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input logic [A-1:0] a, input logic [PW-1:0] d, input int abort_at,
                           input int rst_at, input int ready_dly, input bit poke, input bit noise);
    logic [A+2+D-1:0] bits;
    bits = {d, 2'($urandom), a};
    fr_addr = a;
    fr_data = d;
    if (a == my_addr && abort_at < 0 && rst_at < 0) exp_q.push_back(d);
    frame_start = 1'b1; frame_abort = 1'b0; rx_ready = 1'b0;
    step();
    frame_start = 1'b0;
    for (int t = 1; t <= A + D + 3; t++) begin
      if (t == rst_at) begin
        #2 rstn = 1'b0;
        #1 check_reset("rst_mid");
        @(posedge clk);
        #3 rstn = 1'b1;
        break;
      end
      if (t <= A + 2 + D) bus_bit = bits[t-1];
      else bus_bit = 1'($urandom);
      frame_abort = (t == abort_at);
      if (noise) begin
        rx_ready    = 1'($urandom);
        frame_start = ($urandom_range(0, 7) == 0) && !frame_abort;
      end
      step();
      if (t == abort_at) break;
    end
    frame_abort = 1'b0; frame_start = 1'b0; rx_ready = 1'b0;
    if (m_hold) begin
      for (int k = 0; k < ready_dly; k++) begin
        frame_start = poke && (k == ready_dly / 2);
        step();
      end
      frame_start = 1'b0;
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [PW-1:0] d1, d2;
    repeat (2) @(posedge clk);
    #1 check_reset("por");
    rstn = 1'b1;
    step();

    // Address match, immediate accept
    my_addr = 4'hA;
    clear_obs();
    run_frame(4'hA, 15'h5A3C, -1, -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_hit_cycle", hit_cyc, 6);
    chk("t1_valid_cycle", val_cyc, 23);
    chk("t1_payload", got_q[got_q.size()-1], 15'h5A3C);
    chk("t1_valid_after_accept", rx_valid, 0);
    chk("t1_busy_after_accept", busy, 0);
    step();

    // Address mismatch
    my_addr = 4'h3;
    clear_obs();
    run_frame(4'hA, 15'h1234, -1, -1, 0, 1'b0, 1'b0);
    step();
    chk("t2_no_hit", hit_cyc, 32'hFFFF_FFFF);
    chk("t2_no_valid", val_cyc, 32'hFFFF_FFFF);
    chk("t2_busy_fall", fall_cyc, 23);

    // Abort at data bit 7, then a clean frame
    my_addr = 4'hA;
    clear_obs();
    run_frame(4'hA, 15'h7777, A + 3 + 7, -1, 0, 1'b0, 1'b0);
    step();
    chk("t3_no_valid", val_cyc, 32'hFFFF_FFFF);
    chk("t3_busy_fall", fall_cyc, 15);
    d1 = PW'($urandom);
    run_frame(4'hA, d1, -1, -1, 2, 1'b0, 1'b0);
    chk("t3_next_payload", got_q[got_q.size()-1], d1);
    step();

    // Backpressure with a frame_start during HOLD
    clear_obs();
    run_frame(4'hA, 15'h2B6D, -1, -1, 10, 1'b1, 1'b0);
    chk("t4_overrun_pulses", ovr_cnt, 1);
    chk("t4_payload", got_q[got_q.size()-1], 15'h2B6D);
    step();

    // Reset in the middle of the data field, then a clean frame
    run_frame(4'hA, 15'h0F0F, -1, A + 3 + 5, 0, 1'b0, 1'b0);
    step();
    d1 = PW'($urandom);
    run_frame(4'hA, d1, -1, -1, 1, 1'b0, 1'b0);
    chk("t5_next_payload", got_q[got_q.size()-1], d1);
    step();

    // Back-to-back frames
    d1 = PW'($urandom);
    d2 = PW'($urandom);
    run_frame(4'hA, d1, -1, -1, 0, 1'b0, 1'b0);
    run_frame(4'hA, d2, -1, -1, 3, 1'b0, 1'b0);
    chk("t6_first", got_q[got_q.size()-2], d1);
    chk("t6_second", got_q[got_q.size()-1], d2);
    step();

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      logic [A-1:0] a;
      logic [PW-1:0] d;
      int ab;
      my_addr = A'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? my_addr : A'($urandom);
      d  = PW'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, A + D + 3)) : -1;
      run_frame(a, d, ab, -1, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    chk("payload_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("payload_order", got_q[i], exp_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp_rx_sequencer.md
Name: sp_rx_sequencer

Overview:
Slave-side receive sequencer that owns one serial_parallel converter instance and steps it through a bus frame. It programs the converter's bit_length and en for the ADDRESS field, compares the result with the node address, then re-arms the converter for the DATA field. A matched payload is presented on a valid/ready port to the node's local logic. It sits between the bus line receiver and the slave's register or memory interface.

Parameters:
PORT_WIDTH, 15, converter parallel width; also width of sp_dout and rx_data.
EXTRACT_LNGTH, 4, width of the converter bit_length port.
ADDR_LEN, 4, address field length in bits; 1 <= ADDR_LEN <= PORT_WIDTH.
DATA_LEN, 15, data field length in bits; 1 <= DATA_LEN <= PORT_WIDTH and DATA_LEN <= 2^EXTRACT_LNGTH-1.

Ports:
clk  in  1  single system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
frame_start  in  1  one-cycle pulse; the first address bit is on the bus in the following cycle.
frame_abort  in  1  bus released or error; cancels the frame in any state.
my_addr  in  ADDR_LEN  this node's address.
sp_en  out  1  converter enable, registered.
sp_bit_length  out  EXTRACT_LNGTH  converter field length, registered.
sp_dout  in  PORT_WIDTH  converter parallel output.
sp_dv  in  1  converter done flag.
rx_data  out  PORT_WIDTH  captured payload.
rx_valid  out  1  payload valid; held until accepted.
rx_ready  in  1  consumer accept.
addr_hit  out  1  one-cycle pulse when the address matches.
overrun  out  1  one-cycle pulse when frame_start arrives while rx_valid is high.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE, sp_en=0, sp_bit_length=0, rx_data=0, rx_valid=0, addr_hit=0, overrun=0, busy=0. Reset taken mid-frame drops the frame silently.
- States: IDLE, ADDR, GAP, DATA, SKIP, HOLD.
- Frame format on the bus: ADDR_LEN address bits, then 2 gap bit-cycles, then DATA_LEN data bits. Bits arrive one per clk, LSB first, and are packed by the converter.
- IDLE:
  - frame_start=1 -> ADDR; sp_en<=1, sp_bit_length<=ADDR_LEN.
  - Address bits are on the bus in cycles 1..ADDR_LEN, where cycle 0 is the frame_start cycle.
- ADDR, on sp_dv=1 (cycle ADDR_LEN+1):
  - sp_en<=0 in all cases.
  - If sp_dout[ADDR_LEN-1:0]==my_addr: addr_hit pulses next cycle, sp_bit_length<=DATA_LEN, go to GAP.
  - On mismatch: go to SKIP.
- GAP (cycle ADDR_LEN+2): sp_en=0, which clears the converter. Next cycle sp_en<=1, go to DATA. Data bits occupy cycles ADDR_LEN+3 .. ADDR_LEN+2+DATA_LEN.
- DATA, on sp_dv=1: rx_data<=sp_dout[PORT_WIDTH-1:0], rx_valid<=1, sp_en<=0, go to HOLD. rx_valid is therefore first high in cycle ADDR_LEN+DATA_LEN+4.
- HOLD: rx_valid stays high and rx_data stays stable while rx_ready=0. rx_valid&&rx_ready -> rx_valid<=0, go to IDLE.
- SKIP: sp_en=0. Stays until the frame length elapses, counted as 2+DATA_LEN cycles after entry, then goes to IDLE. No rx_valid and no addr_hit.
- frame_abort=1 in ADDR, GAP, DATA or SKIP -> IDLE next cycle, sp_en<=0, rx_valid is not asserted. frame_abort in HOLD is ignored, because the payload is already complete.
- frame_start in HOLD: overrun pulses and the frame is ignored.
- frame_start in any other non-IDLE state: ignored, no overrun.
- Simultaneous events:
  - frame_abort wins over sp_dv.
  - rx_ready in the same cycle rx_valid rises has no effect; the handshake is evaluated on registered rx_valid.
- sp_bit_length holds its last value in IDLE. No arithmetic wraps: the SKIP counter is ceil(log2(DATA_LEN+3)) bits wide.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE..HOLD, STATE_BW=3);
  - the GAP_CYCLES=2 constant;
  - the frame-format constants ADDR_LEN and DATA_LEN, shared with the bus master's transmit sequencer.
- The block is one FSM plus the SKIP counter. The serial_parallel instance stays outside; the parent wires sp_* to it. No sub-module.

Test Plan:
1. Match. ADDR_LEN=4, DATA_LEN=15, my_addr=4'hA. Frame start, address bits 0,1,0,1, 2 gap cycles, data=15'h5A3C. Expected: addr_hit pulses at cycle 6; rx_valid=1 with rx_data=15'h5A3C at cycle 23; rx_ready=1 -> rx_valid=0 next cycle, busy=0.
2. Mismatch. my_addr=4'h3, frame address=4'hA. Expected: goes to SKIP; no addr_hit; rx_valid stays 0; busy falls after 17 cycles in SKIP.
3. Abort. frame_abort at data bit 7. Expected: sp_en=0 and IDLE next cycle; rx_valid never rises. A new frame that follows is received correctly.
4. Backpressure. Hold rx_ready=0 for 10 cycles after rx_valid. Expected: rx_data stays stable. frame_start during HOLD pulses overrun=1 for one cycle and rx_data is unchanged.
5. Reset mid-DATA. rstn=0 for 1 cycle. Expected: all outputs take their reset values immediately, asynchronously. The next frame is received correctly.
6. Back-to-back frames. frame_start one cycle after the accept of the previous frame. Expected: both payloads are delivered in order with correct values.
